// File: rtl/string_reader_if.sv
// Handshake and memory-port bundle for string_reader: request in, word reads out,
// character stream out, completion status out.
interface string_reader_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  char_data;
  logic        done;
  logic        truncated;
  logic        busy;

  modport slave (
    input  req_valid, req_addr, mem_rd_data, char_ready,
    output req_ready, mem_addr, mem_rd_en, char_valid, char_data, done, truncated, busy
  );

  modport master (
    output req_valid, req_addr, mem_rd_data, char_ready,
    input  req_ready, mem_addr, mem_rd_en, char_valid, char_data, done, truncated, busy
  );
endinterface

// File: rtl/string_reader.sv
// Streams a NUL-terminated byte string out of a word-wide memory, one character per
// handshake, fetching a new word only when a 4-byte boundary is crossed.
module string_reader #(
  parameter int unsigned MAX_LEN = 256
) (
  input  logic           clk,
  input  logic           rst,
  string_reader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      2'd3:    return word[31:24];
      default: return word[7:0];
    endcase
  endfunction

  state_t      state_r;
  logic [31:0] ptr_r;
  logic [31:0] word_r;
  logic [15:0] cnt_r;
  logic        req_ready_r;
  logic        mem_rd_en_r;
  logic        char_valid_r;
  logic [7:0]  char_data_r;
  logic        done_r;
  logic        truncated_r;
  logic        busy_r;

  logic [16:0] cnt_next_s;
  logic [7:0]  fetch_byte_s;
  logic [7:0]  next_byte_s;

  assign cnt_next_s   = {1'b0, cnt_r} + 17'd1;
  assign fetch_byte_s = byte_sel(bus.mem_rd_data, ptr_r[1:0]);
  // Only consulted when ptr[1:0] != 3, so the +1 never needs to leave the buffered word.
  assign next_byte_s  = byte_sel(word_r, ptr_r[1:0] + 2'd1);

  assign bus.req_ready  = req_ready_r;
  assign bus.mem_addr   = {ptr_r[31:2], 2'b00};
  assign bus.mem_rd_en  = mem_rd_en_r;
  assign bus.char_valid = char_valid_r;
  assign bus.char_data  = char_data_r;
  assign bus.done       = done_r;
  assign bus.truncated  = truncated_r;
  assign bus.busy       = busy_r;

  // Control FSM with all outputs registered alongside the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      ptr_r        <= 32'd0;
      word_r       <= 32'd0;
      cnt_r        <= 16'd0;
      req_ready_r  <= 1'b0;
      mem_rd_en_r  <= 1'b0;
      char_valid_r <= 1'b0;
      char_data_r  <= 8'h00;
      done_r       <= 1'b0;
      truncated_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      truncated_r <= 1'b0;
      case (state_r)
        IDLE: begin
          req_ready_r <= 1'b1;
          if (bus.req_valid && req_ready_r) begin
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (bus.req_addr != 32'd0) begin
              ptr_r       <= bus.req_addr;
              cnt_r       <= 16'd0;
              mem_rd_en_r <= 1'b1;
              state_r     <= FETCH;
            end else begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        FETCH: begin
          word_r       <= bus.mem_rd_data;
          mem_rd_en_r  <= 1'b0;
          char_data_r  <= fetch_byte_s;
          char_valid_r <= (fetch_byte_s != 8'h00);
          state_r      <= EMIT;
        end
        EMIT: begin
          // char_valid low in EMIT means the current byte is the terminating NUL.
          if (!char_valid_r) begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end else if (bus.char_ready) begin
            ptr_r <= ptr_r + 32'd1;
            cnt_r <= cnt_next_s[15:0];
            if (cnt_next_s == MAX_LEN_W) begin
              char_valid_r <= 1'b0;
              done_r       <= 1'b1;
              truncated_r  <= 1'b1;
              state_r      <= DONE;
            end else if (ptr_r[1:0] == 2'b11) begin
              char_valid_r <= 1'b0;
              mem_rd_en_r  <= 1'b1;
              state_r      <= FETCH;
            end else begin
              char_data_r  <= next_byte_s;
              char_valid_r <= (next_byte_s != 8'h00);
            end
          end
        end
        DONE: begin
          busy_r      <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          mem_rd_en_r  <= 1'b0;
          char_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          req_ready_r  <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/string_reader.md
STRING_READER -- requirements
Module: string_reader

Interface
REQ-001 SHALL have parameter MAX_LEN, default 256, meaning the maximum number of characters emitted per request (range 1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  request to stream a NUL-terminated string.
REQ-005 SHALL have port req_addr  input  32  byte address of the first character.
REQ-006 SHALL have port req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready at a rising edge.
REQ-007 SHALL have port mem_addr  output  32  word-aligned byte address to the memory data read port ({ptr[31:2],2'b00}).
REQ-008 SHALL have port mem_rd_en  output  1  high during FETCH only.
REQ-009 SHALL have port mem_rd_data  input  32  word at mem_addr, valid combinationally in the same cycle; byte n in bits [8n+7:8n].
REQ-010 SHALL have port char_valid  output  1  char_data holds a character.
REQ-011 SHALL have port char_ready  input  1  consumer accepts the character when char_valid && char_ready at a rising edge.
REQ-012 SHALL have port char_data  output  8  current character.
REQ-013 SHALL have port done  output  1  one-cycle pulse at end of each accepted request.
REQ-014 SHALL have port truncated  output  1  valid with done; high when MAX_LEN reached before NUL.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, FETCH, EMIT, DONE with registered state, 32-bit pointer ptr, 32-bit word buffer, 16-bit char counter.
REQ-017 IDLE: on accepted request with req_addr != 0 SHALL load ptr=req_addr, counter=0, go FETCH; with req_addr == 0 SHALL go DONE directly (truncated=0, no memory access).
REQ-018 FETCH: SHALL drive mem_rd_en=1, capture mem_rd_data into the word buffer at the edge, go EMIT; exactly one cycle.
REQ-019 EMIT: current byte = buffer[8*ptr[1:0]+7 : 8*ptr[1:0]]; if byte == 8'h00 SHALL go DONE with truncated=0 and char_valid=0 (NUL never emitted).
REQ-020 EMIT, byte nonzero: SHALL drive char_valid=1, char_data=byte; char_data and char_valid SHALL stay stable until handshake.
REQ-021 On handshake: ptr <= ptr+1 (modulo 2^32, wraps 0xFFFFFFFF->0), counter <= counter+1.
REQ-022 On handshake, if counter+1 == MAX_LEN SHALL go DONE with truncated=1; else if ptr[1:0]==2'b11 SHALL go FETCH; else stay EMIT.
REQ-023 DONE: done=1 for exactly one cycle, truncated held for that cycle, then IDLE.
REQ-024 Latency: request accepted at edge 0 -> mem_rd_en high cycle 1 -> first char_valid cycle 2; one fetch cycle per 4-byte boundary crossed, no other bubbles when char_ready held high.
REQ-025 req_valid outside IDLE SHALL be ignored (no queuing).
REQ-026 mem_addr SHALL hold {ptr[31:2],2'b00} in every state; mem_rd_en SHALL be 0 outside FETCH.

Reset
REQ-027 rst high SHALL immediately force IDLE, ptr=0, counter=0, buffer=0; outputs char_valid=0, done=0, truncated=0, busy=0, mem_rd_en=0, req_ready=0 while rst high, req_ready=1 from first edge after release.
REQ-028 Reset mid-stream SHALL abort with no done pulse; next request after release starts cleanly.

Verification
REQ-029 Memory 0x100=0x6C6C6568, 0x104=0x0000006F, req_addr=0x100, char_ready=1 -> chars 68,65,6C,6C,6F, 2 fetches, done with truncated=0 one cycle after the final character's handshake cycle.
REQ-030 Unaligned start: req_addr=0x103, 0x100=0x41000000, 0x104=0x00004342 -> chars 41,42,43; fetches at 0x100 then 0x104.
REQ-031 Empty string (byte at req_addr=00) -> zero chars, done with truncated=0; req_addr=0 -> done on cycle 1 with mem_rd_en never high.
REQ-032 Backpressure: char_ready low 5 cycles on each char -> char_data stable while held, ptr unchanged, same char sequence as REQ-029.
REQ-033 MAX_LEN=3, string "ABCDE" -> chars 41,42,43 then done with truncated=1.
REQ-034 rst asserted after second char of REQ-029 -> busy and char_valid drop same cycle, no done; re-request after release reproduces the full REQ-029 sequence.
